// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: shift-add multiply, restoring divide.
// One op at a time; stalls the pipeline while iterating.
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [4:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [2:0]        r_op;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_mcand;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_result;

  logic [2:0]      w_f3;
  logic            w_is_div;
  logic            w_sgn_a;
  logic            w_sgn_b;
  logic            w_neg_a;
  logic            w_neg_b;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_accept;
  logic            w_div0;
  logic            w_ovf;
  logic            w_fast;
  logic [XLEN-1:0] w_fast_res;

  assign w_f3     = alu_ctrl[2:0];
  assign w_is_div = w_f3[2];
  assign w_accept = start & alu_ctrl[4]
                  & (r_state == S_IDLE) & ~flush;

  always_comb begin
    w_sgn_a = 1'b0;
    w_sgn_b = 1'b0;
    case (w_f3)
      3'b001: begin w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
      3'b010: w_sgn_a = 1'b1;
      3'b100: begin w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
      3'b110: begin w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
      default: ;
    endcase
  end

  assign w_neg_a = w_sgn_a & op_a[XLEN-1];
  assign w_neg_b = w_sgn_b & op_b[XLEN-1];
  assign w_mag_a = w_neg_a ? -op_a : op_a;
  assign w_mag_b = w_neg_b ? -op_b : op_b;

  // Divide-by-zero and INT_MIN / -1 bypass the iteration.
  assign w_div0 = w_is_div & (op_b == '0);
  assign w_ovf  = w_is_div & ~w_f3[0] & (&op_b)
                & (op_a == {1'b1, {(XLEN-1){1'b0}}});
  assign w_fast = w_div0 | w_ovf;

  always_comb begin
    if (w_div0)
      w_fast_res = w_f3[1] ? op_a : '1;
    else
      w_fast_res = w_f3[1] ? '0 : op_a;
  end

  logic [XLEN:0]     w_msum;
  logic [2*XLEN-1:0] w_mul_nxt;
  logic [XLEN:0]     w_dtry;
  logic [XLEN:0]     w_ddif;
  logic [2*XLEN-1:0] w_div_nxt;

  assign w_msum = {1'b0, r_acc[2*XLEN-1:XLEN]}
                + (r_acc[0] ? {1'b0, r_mcand} : '0);
  assign w_mul_nxt = {w_msum, r_acc[XLEN-1:1]};

  assign w_dtry = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_ddif = w_dtry - {1'b0, r_mcand};
  assign w_div_nxt = w_ddif[XLEN]
    ? {w_dtry[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
    : {w_ddif[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_res;

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_acc[XLEN-1:0]
                          : r_acc[XLEN-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*XLEN-1:XLEN]
                          : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_res = w_prod[2*XLEN-1:XLEN];
    case (r_op)
      3'b000:         w_fix_res = w_prod[XLEN-1:0];
      3'b100, 3'b101: w_fix_res = w_quo;
      3'b110, 3'b111: w_fix_res = w_rem;
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept)
                  w_next = w_fast ? S_DONE : S_CALC;
        S_CALC: if (r_cnt == CNT_W'(1))
                  w_next = S_FIX;
        S_FIX:  w_next = S_DONE;
        S_DONE: w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op    <= w_f3;
      r_neg_q <= w_neg_a ^ w_neg_b;
      r_neg_r <= w_neg_a;
      r_acc   <= {{XLEN{1'b0}},
                  w_is_div ? w_mag_a : w_mag_b};
      r_mcand <= w_is_div ? w_mag_b : w_mag_a;
      r_cnt   <= CNT_W'(XLEN);
      if (w_fast) r_result <= w_fast_res;
    end else if (!flush) begin
      if (r_state == S_CALC) begin
        r_acc <= r_op[2] ? w_div_nxt : w_mul_nxt;
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (r_state == S_FIX) r_result <= w_fix_res;
    end
  end

  assign busy   = (r_state == S_CALC) | (r_state == S_FIX);
  assign stall  = busy | w_accept;
  assign done   = (r_state == S_DONE);
  assign result = r_result;

endmodule
